timer_msmt_arbiter: RTL and testbench

- Shares one timer/averager measurement core between N_CH requesters.
- Each requester posts a start pulse and, later, a stop pulse. The block grants the core round-robin, drives its START/STOP lines with legal pulse spacing, and returns the 32-bit measurement tagged with the channel index.
- Sits between requester logic and the core's START_TIMER/STOP_TIMER/MSMT_VALUE/MSMT_VALID ports.
- Adds a per-measurement run timeout and a result watchdog.

---
 rtl/timer_msmt_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_timer_msmt_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_msmt_arbiter.sv
// Round-robin arbiter sharing one timer/averager measurement core between N_CH requesters.
// Paces the core's START/STOP pulses, enforces a run timeout and a result watchdog.
module timer_msmt_arbiter #(
  parameter int N_CH     = 4,
  parameter int RES_WDOG = 8,
  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] REQ_START,
  input  logic [N_CH-1:0] REQ_STOP,
  input  logic [31:0]     TIMEOUT_LIMIT,
  output logic            TIMER_START,
  output logic            TIMER_STOP,
  input  logic [31:0]     TIMER_MSMT_VALUE,
  input  logic            TIMER_MSMT_VALID,
  output logic [31:0]     RES_VALUE,
  output logic            RES_VALID,
  output logic [CW-1:0]   RES_CH,
  output logic            RES_TIMEOUT,
  output logic [N_CH-1:0] GRANT,
  output logic [N_CH-1:0] PENDING,
  output logic            BUSY
);

  localparam int WDW = $clog2(RES_WDOG + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(RES_WDOG - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]      r_state;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_grant;
  logic [CW-1:0]   r_ch;
  logic [CW-1:0]   r_ptr;
  logic [31:0]     r_run_cnt;
  logic            r_stop_seen;
  logic            r_to_flag;
  logic [WDW-1:0]  r_wdog;
  logic            r_timer_start;
  logic            r_timer_stop;
  logic            r_busy;
  logic [31:0]     r_res_value;
  logic            r_res_valid;
  logic [CW-1:0]   r_res_ch;
  logic            r_res_timeout;

  logic [2:0]      w_state_nxt;
  logic            w_found;
  logic [CW-1:0]   w_sel_idx;
  logic [N_CH-1:0] w_sel_oh;
  logic [CW-1:0]   w_ptr_nxt;
  logic [N_CH-1:0] w_own;
  logic [N_CH-1:0] w_pend_nxt;
  logic            w_stop_req;
  logic            w_dwell_done;
  logic            w_limit_hit;
  logic            w_grant_go;
  logic            w_exit_stop;
  logic            w_exit_to;
  logic            w_res_hit;
  logic            w_res_lost;
  int unsigned     w_j;

  // First pending channel at or after the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sel_oh  = '0;
    w_j       = 0;
    for (int unsigned k = 0; k < unsigned'(N_CH); k++) begin
      w_j = k + 32'(r_ptr);
      if (w_j >= unsigned'(N_CH)) w_j = w_j - unsigned'(N_CH);
      if (!w_found && r_pending[w_j[CW-1:0]]) begin
        w_found                = 1'b1;
        w_sel_idx              = w_j[CW-1:0];
        w_sel_oh[w_j[CW-1:0]]  = 1'b1;
      end
    end
  end

  assign w_ptr_nxt    = (w_sel_idx == CW'(N_CH - 1)) ? '0 : w_sel_idx + CW'(1);
  assign w_own        = (r_state != S_IDLE) ? r_grant : '0;
  assign w_stop_req   = |(REQ_STOP & r_grant);
  assign w_dwell_done = (r_run_cnt >= 32'd2);
  assign w_limit_hit  = (TIMEOUT_LIMIT != '0) && (r_run_cnt >= TIMEOUT_LIMIT - 32'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    w_exit_stop = 1'b0;
    w_exit_to   = 1'b0;
    w_res_hit   = 1'b0;
    w_res_lost  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_go  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        // Both exits wait out the dwell; a stop beats a same-cycle timeout.
        if (w_dwell_done && (r_stop_seen || w_stop_req)) begin
          w_exit_stop = 1'b1;
          w_state_nxt = S_STOP;
        end else if (w_dwell_done && w_limit_hit) begin
          w_exit_to   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (TIMER_MSMT_VALID) begin
          w_res_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog >= WDOG_LAST) begin
          w_res_lost  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pend_nxt = (r_pending | (REQ_START & ~w_own)) & ~(w_grant_go ? w_sel_oh : '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_grant       <= '0;
      r_ch          <= '0;
      r_ptr         <= '0;
      r_run_cnt     <= '0;
      r_stop_seen   <= 1'b0;
      r_to_flag     <= 1'b0;
      r_wdog        <= '0;
      r_timer_start <= 1'b0;
      r_timer_stop  <= 1'b0;
      r_busy        <= 1'b0;
      r_res_value   <= '0;
      r_res_valid   <= 1'b0;
      r_res_ch      <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pend_nxt;
      r_timer_start <= (w_state_nxt == S_START);
      r_timer_stop  <= (w_state_nxt == S_STOP);
      r_busy        <= (w_state_nxt != S_IDLE);

      // GRANT survives into the RES_VALID cycle and clears on the following idle cycle.
      if (w_grant_go) begin
        r_grant <= w_sel_oh;
        r_ch    <= w_sel_idx;
        r_ptr   <= w_ptr_nxt;
      end else if (r_state == S_IDLE) begin
        r_grant <= '0;
      end

      if (r_state == S_RUN) begin
        if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 32'd1;
      end else begin
        r_run_cnt <= '0;
      end

      if (r_state != S_RUN) r_stop_seen <= 1'b0;
      else if (!w_dwell_done && w_stop_req) r_stop_seen <= 1'b1;

      if (w_exit_stop)    r_to_flag <= 1'b0;
      else if (w_exit_to) r_to_flag <= 1'b1;

      if (r_state == S_STOP)      r_wdog <= WDW'(1);
      else if (r_state == S_WAIT) r_wdog <= r_wdog + WDW'(1);

      r_res_valid <= w_res_hit | w_res_lost;
      if (w_res_hit) begin
        r_res_value   <= TIMER_MSMT_VALUE;
        r_res_ch      <= r_ch;
        r_res_timeout <= r_to_flag;
      end else if (w_res_lost) begin
        r_res_value   <= '1;
        r_res_ch      <= r_ch;
        r_res_timeout <= 1'b1;
      end
    end
  end

  assign TIMER_START = r_timer_start;
  assign TIMER_STOP  = r_timer_stop;
  assign RES_VALUE   = r_res_value;
  assign RES_VALID   = r_res_valid;
  assign RES_CH      = r_res_ch;
  assign RES_TIMEOUT = r_res_timeout;
  assign GRANT       = r_grant;
  assign PENDING     = r_pending;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_timer_msmt_arbiter.sv
// Directed bench for timer_msmt_arbiter: table of single measurements plus
// round-robin and reset-abort sequences, with a small core response model.
module tb_timer_msmt_arbiter;

  localparam int N_CH     = 4;
  localparam int RES_WDOG = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  REQ_START, REQ_STOP;
  logic [31:0] TIMEOUT_LIMIT;
  logic        TIMER_START, TIMER_STOP;
  logic [31:0] TIMER_MSMT_VALUE;
  logic        TIMER_MSMT_VALID;
  logic [31:0] RES_VALUE;
  logic        RES_VALID;
  logic [1:0]  RES_CH;
  logic        RES_TIMEOUT;
  logic [3:0]  GRANT, PENDING;
  logic        BUSY;

  timer_msmt_arbiter #(.N_CH(N_CH), .RES_WDOG(RES_WDOG)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_START(REQ_START), .REQ_STOP(REQ_STOP),
    .TIMEOUT_LIMIT(TIMEOUT_LIMIT), .TIMER_START(TIMER_START), .TIMER_STOP(TIMER_STOP),
    .TIMER_MSMT_VALUE(TIMER_MSMT_VALUE), .TIMER_MSMT_VALID(TIMER_MSMT_VALID),
    .RES_VALUE(RES_VALUE), .RES_VALID(RES_VALID), .RES_CH(RES_CH),
    .RES_TIMEOUT(RES_TIMEOUT), .GRANT(GRANT), .PENDING(PENDING), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          ch;
    int          d;       // REQ_STOP this many cycles after TIMER_START, 0 = never
    logic [31:0] lim;
    int          lat;     // core MSMT_VALID this many cycles after TIMER_STOP, 0 = never
    logic [31:0] val;
    int          e_stop;  // TIMER_STOP cycle minus TIMER_START cycle
    int          e_res;   // RES_VALID cycle minus TIMER_STOP cycle
    logic [31:0] e_val;
    logic        e_to;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [1:0]  ch;
    logic        to;
    logic [3:0]  g;
  } res_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start, n_stop, n_resv, start_cyc, stop_cyc;
  res_t res_q[$];
  int core_lat = 2;
  logic [31:0] core_val = 32'h0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (TIMER_START) begin n_start++; start_cyc = cyc; end
    if (TIMER_STOP)  begin n_stop++;  stop_cyc  = cyc; end
    if (RES_VALID) begin
      n_resv++;
      res_q.push_back('{cyc, RES_VALUE, RES_CH, RES_TIMEOUT, GRANT});
    end
  end

  // Core model: one MSMT_VALID pulse core_lat cycles after a TIMER_STOP pulse.
  initial begin
    TIMER_MSMT_VALID = 1'b0;
    TIMER_MSMT_VALUE = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (TIMER_STOP && core_lat > 0) begin
        repeat (core_lat) begin @(posedge CLK); #1; end
        TIMER_MSMT_VALUE = core_val;
        TIMER_MSMT_VALID = 1'b1;
        @(posedge CLK);
        #1;
        TIMER_MSMT_VALID = 1'b0;
        TIMER_MSMT_VALUE = 32'hDEAD_0000;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic clear_logs();
    n_start = 0; n_stop = 0; n_resv = 0; start_cyc = 0; stop_cyc = 0;
    res_q.delete();
  endtask

  task automatic wait_start(output bit ok);
    for (int i = 0; i < 40; i++) begin
      if (TIMER_START) break;
      tick();
    end
    ok = TIMER_START;
    chk("start_wait", 32'(TIMER_START), 32'd1);
  endtask

  task automatic wait_res(output bit ok);
    for (int i = 0; i < 60; i++) begin
      if (res_q.size() > 0) break;
      tick();
    end
    ok = (res_q.size() > 0);
    chk("res_wait", 32'(res_q.size()), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int s;
    res_t r;
    clear_logs();
    TIMEOUT_LIMIT = v.lim;
    core_lat = v.lat;
    core_val = v.val;
    REQ_START = 4'(1 << v.ch);
    tick();
    REQ_START = '0;
    tick();
    chk("start_latency", 32'(TIMER_START), 32'd1);
    chk("grant_start", 32'(GRANT), 32'd1 << v.ch);
    chk("busy_start", 32'(BUSY), 32'd1);
    s = cyc;
    if (v.d > 0) begin
      repeat (v.d) tick();
      REQ_STOP = 4'(1 << v.ch);
      tick();
      REQ_STOP = '0;
    end
    wait_res(ok);
    if (ok) begin
      r = res_q[0];
      chk("stop_offset", 32'(stop_cyc - s), 32'(v.e_stop));
      chk("res_offset", 32'(r.cyc - stop_cyc), 32'(v.e_res));
      chk("res_value", r.val, v.e_val);
      chk("res_ch", 32'(r.ch), 32'(v.ch));
      chk("res_timeout", 32'(r.to), 32'(v.e_to));
      chk("grant_at_res", 32'(r.g), 32'd1 << v.ch);
    end
    tick();
    tick();
    chk("n_start", 32'(n_start), 32'd1);
    chk("n_stop", 32'(n_stop), 32'd1);
    chk("res_valid_width", 32'(n_resv), 32'd1);
    chk("grant_after", 32'(GRANT), 32'd0);
    chk("busy_after", 32'(BUSY), 32'd0);
    chk("res_value_hold", RES_VALUE, v.e_val);
  endtask

  task automatic serve(input int ch);
    bit ok;
    wait_start(ok);
    chk("rr_grant", 32'(GRANT), 32'd1 << ch);
    core_val = 32'h100 + 32'(ch);
    repeat (10) tick();
    REQ_STOP = 4'(1 << ch);
    tick();
    REQ_STOP = '0;
    wait_res(ok);
    if (ok) begin
      chk("rr_res_ch", 32'(res_q[0].ch), 32'(ch));
      chk("rr_res_value", res_q[0].val, 32'h100 + 32'(ch));
      res_q.delete();
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  vec_t vecs[8];
  vec_t v_after;

  initial begin
    vecs[0] = '{0, 18, 32'd0, 2, 32'h13,   19, 3, 32'h13,        1'b0}; // single request
    vecs[1] = '{2,  1, 32'd0, 1, 32'hA5A5,  4, 2, 32'hA5A5,      1'b0}; // stop inside dwell
    vecs[2] = '{1,  0, 32'd5, 3, 32'h77,    6, 4, 32'h77,        1'b1}; // run timeout
    vecs[3] = '{1,  5, 32'd5, 3, 32'h78,    6, 4, 32'h78,        1'b0}; // stop in last RUN cycle
    vecs[4] = '{3,  4, 32'd0, 0, 32'h0,     5, 8, 32'hFFFF_FFFF, 1'b1}; // lost result
    vecs[5] = '{2,  2, 32'd0, 7, 32'h1234,  4, 8, 32'h1234,      1'b0}; // valid on watchdog edge
    vecs[6] = '{0,  3, 32'd3, 1, 32'h55,    4, 2, 32'h55,        1'b0}; // stop meets timeout
    vecs[7] = '{3,  0, 32'd3, 2, 32'h9,     4, 3, 32'h9,         1'b1}; // timeout at dwell end
    v_after = '{1,  6, 32'd0, 2, 32'h42,    7, 3, 32'h42,        1'b0};

    RESET = 1'b1;
    REQ_START = '0;
    REQ_STOP = '0;
    TIMEOUT_LIMIT = '0;
    repeat (3) tick();
    chk("rst_timer_start", 32'(TIMER_START), 32'd0);
    chk("rst_timer_stop", 32'(TIMER_STOP), 32'd0);
    chk("rst_res_valid", 32'(RES_VALID), 32'd0);
    chk("rst_res_value", RES_VALUE, 32'd0);
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_pending", 32'(PENDING), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round-robin from pointer 0: 0,1,3 then 0,3.
    do_reset();
    clear_logs();
    TIMEOUT_LIMIT = '0;
    core_lat = 2;
    REQ_START = 4'b1011;
    tick();
    REQ_START = '0;
    chk("rr_pending_set", 32'(PENDING), 32'h0000_000B);
    serve(0);
    serve(1);
    serve(3);
    REQ_START = 4'b1001;
    tick();
    REQ_START = '0;
    chk("rr_pending_2", 32'(PENDING), 32'h0000_0009);
    serve(0);
    serve(3);
    repeat (3) tick();
    chk("rr_idle", 32'(BUSY), 32'd0);

    // Reset in RUN with channel 1 pending; REQ_START from the owner is dropped.
    clear_logs();
    REQ_START = 4'b0001;
    tick();
    REQ_START = '0;
    tick();
    chk("ab_start", 32'(TIMER_START), 32'd1);
    tick();
    REQ_START = 4'b0011;
    tick();
    REQ_START = '0;
    chk("ab_pending_own_ignored", 32'(PENDING), 32'd2);
    tick();
    RESET = 1'b1;
    tick();
    chk("ab_grant", 32'(GRANT), 32'd0);
    chk("ab_pending", 32'(PENDING), 32'd0);
    chk("ab_busy", 32'(BUSY), 32'd0);
    chk("ab_res_value", RES_VALUE, 32'd0);
    chk("ab_res_ch", 32'(RES_CH), 32'd0);
    chk("ab_res_timeout", 32'(RES_TIMEOUT), 32'd0);
    chk("ab_timer_stop", 32'(TIMER_STOP), 32'd0);
    RESET = 1'b0;
    repeat (12) tick();
    chk("ab_no_result", 32'(n_resv), 32'd0);
    chk("ab_no_stop", 32'(n_stop), 32'd0);
    chk("ab_pending_idle", 32'(PENDING), 32'd0);
    run_vec(v_after);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
